// File: rtl/ion_frame_serializer_pkg.sv
// Shared definitions for the ion frame serializer: FSM state encoding,
// default sync byte and frame geometry constants.
package ion_frame_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_MASK    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // sync + mask + payload + checksum
  localparam int FRAME_LEN     = 17;
  localparam int PAYLOAD_BYTES = FRAME_LEN - 3;
  localparam int PAYLOAD_PAD_W = PAYLOAD_BYTES * 8;

endpackage

// File: rtl/ion_frame_serializer_frame_checksum.sv
// Byte-wide XOR accumulator used for the frame checksum.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   clear_i  - zero the accumulator (start of a new frame)
//   en_i     - fold byte_i into the accumulator
//   byte_i   - byte to accumulate
//   csum_o   - current accumulated XOR
module frame_checksum (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = 8'h00;
    end else if (en_i) begin
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/ion_frame_serializer.sv
// Captures a sensor mask and payload from the ion stage and streams it out
// as a framed byte sequence: SYNC, mask, payload bytes MSB-first, checksum.
// Ports:
//   clock, reset - system clock (rising edge), synchronous active-high reset
//   ready        - per-sensor mask; nonzero offers a frame
//   data_in      - sensor payload
//   taken        - one-cycle pulse when ready/data_in are captured
//   tx_data      - byte to the transmitter (00 when idle)
//   tx_valid     - tx_data is valid
//   tx_ready     - transmitter accepts the byte this cycle
//   busy         - a frame is in progress
module ion_frame_serializer
  import ion_frame_serializer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         PAYLOAD_W = 110
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           ready,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 taken,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [7:0]               mask_q, mask_d;
  logic [PAYLOAD_PAD_W-1:0] payload_q, payload_d;
  logic                     capture;
  logic                     csum_en;
  logic [7:0]               csum;

  frame_checksum u_checksum (
    .clock   (clock),
    .reset   (reset),
    .clear_i (capture),
    .en_i    (csum_en),
    .byte_i  (tx_data),
    .csum_o  (csum)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    payload_d = payload_q;
    capture   = 1'b0;
    csum_en   = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        tx_valid = 1'b0;
        if (ready != 8'h00) begin
          capture   = 1'b1;
          mask_d    = ready;
          // width cast zero-pads the payload on the left
          payload_d = PAYLOAD_PAD_W'(data_in);
          idx_d     = 4'd0;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        tx_data = SYNC_BYTE;
        if (tx_ready) state_d = ST_MASK;
      end
      ST_MASK: begin
        tx_data = mask_q;
        if (tx_ready) begin
          csum_en = 1'b1;
          idx_d   = 4'd0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // payload register shifts left so the current byte is always on top
        tx_data = payload_q[PAYLOAD_PAD_W-1 -: 8];
        if (tx_ready) begin
          csum_en   = 1'b1;
          payload_d = payload_q << 8;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'(PAYLOAD_BYTES - 1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tx_data = csum;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: begin
        tx_valid = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      mask_q    <= 8'h00;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      payload_q <= payload_d;
    end
  end

  // a capture is suppressed by a coincident reset, so the pulse is too
  assign taken = capture & ~reset;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ion_frame_serializer.sv
module tb_ion_frame_serializer;

  localparam int PW = 110;

  typedef logic [7:0] frame_t [17];

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    ready;
  logic [PW-1:0] data_in;
  logic          taken;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;

  always #5 clock = ~clock;

  ion_frame_serializer #(.SYNC_BYTE(8'hA5), .PAYLOAD_W(PW)) dut (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .data_in  (data_in),
    .taken    (taken),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference frame built straight from the frame definition.
  function automatic frame_t build_frame(logic [7:0] m, logic [PW-1:0] d);
    frame_t       f;
    logic [111:0] w;
    logic [7:0]   cs;
    w    = 112'(d);
    f[0] = 8'hA5;
    f[1] = m;
    cs   = m;
    for (int k = 0; k < 14; k++) begin
      f[2+k] = 8'((w >> (8 * (13 - k))) & 112'hFF);
      cs     = cs ^ f[2+k];
    end
    f[16] = cs;
    return f;
  endfunction

  // Model: queue of bytes still owed by the current frame; empty means idle.
  logic [7:0] exp_q[$];
  logic [7:0] acc_bytes[$];
  int         cyc = 0;
  int         taken_cnt = 0;
  int         last_taken = -1;
  int         prev_taken = -1;
  int         valid_cnt = 0;
  logic       m_idle;
  frame_t     mf;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      m_idle = (exp_q.size() == 0);
      check("busy", busy, !m_idle);
      check("tx_valid", tx_valid, !m_idle);
      check("tx_data", tx_data, m_idle ? 8'h00 : exp_q[0]);
      check("taken", taken, m_idle && (ready != 8'h00));
      if (taken) begin
        taken_cnt++;
        prev_taken = last_taken;
        last_taken = cyc;
      end
      if (tx_valid) valid_cnt++;
      if (tx_valid && tx_ready) acc_bytes.push_back(tx_data);
      if (m_idle && ready != 8'h00) begin
        mf = build_frame(ready, data_in);
        for (int i = 0; i < 17; i++) exp_q.push_back(mf[i]);
      end else if (!m_idle && tx_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (!busy) break;
      step();
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", lim);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic send_frame(input logic [7:0] m, input logic [PW-1:0] d);
    ready   = m;
    data_in = d;
    step();
    ready = 8'h00;
  endtask

  frame_t f;
  int     t0;

  initial begin
    reset    = 1'b1;
    ready    = 8'h00;
    data_in  = '0;
    tx_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_taken", taken, 1'b0);

    // pin the model with hand-computed frames
    f = build_frame(8'h01, PW'(1));
    check("model_sync", f[0], 8'hA5);
    check("model_p0_basic", f[2], 8'h00);
    check("model_p13_basic", f[15], 8'h01);
    check("model_cs_basic", f[16], 8'h00);
    f = build_frame(8'h80, '1);
    check("model_p0_ones", f[2], 8'h3F);
    check("model_p1_ones", f[3], 8'hFF);
    check("model_cs_ones", f[16], 8'h40);

    // basic frame
    acc_bytes.delete();
    t0 = taken_cnt;
    send_frame(8'h01, PW'(1));
    wait_idle(40);
    check("basic_len", acc_bytes.size(), 17);
    if (acc_bytes.size() == 17) begin
      check("basic_sync", acc_bytes[0], 8'hA5);
      check("basic_mask", acc_bytes[1], 8'h01);
      check("basic_p13", acc_bytes[15], 8'h01);
      check("basic_cs", acc_bytes[16], 8'h00);
    end
    check("basic_taken_once", taken_cnt - t0, 1);

    // all-ones payload checksum
    acc_bytes.delete();
    send_frame(8'h80, '1);
    wait_idle(40);
    check("ones_len", acc_bytes.size(), 17);
    if (acc_bytes.size() == 17) begin
      check("ones_p0", acc_bytes[2], 8'h3F);
      check("ones_p13", acc_bytes[15], 8'hFF);
      check("ones_cs", acc_bytes[16], 8'h40);
    end

    // backpressure: tx_ready alternates 0/1
    acc_bytes.delete();
    valid_cnt = 0;
    send_frame(8'h01, PW'(1));
    for (int i = 0; i < 80 && busy; i++) begin
      tx_ready = 1'(i % 2);
      step();
    end
    tx_ready = 1'b1;
    check("bp_valid_cycles", valid_cnt, 34);
    check("bp_len", acc_bytes.size(), 17);

    // inputs changing while busy are ignored
    t0 = taken_cnt;
    send_frame(8'h5A, rand_payload());
    for (int i = 0; i < 10; i++) begin
      ready   = 8'($urandom_range(1, 255));
      data_in = rand_payload();
      step();
    end
    ready = 8'h00;
    wait_idle(40);
    check("ignore_taken_once", taken_cnt - t0, 1);

    // reset after five bytes
    send_frame(8'h33, rand_payload());
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    acc_bytes.delete();
    send_frame(8'h0F, rand_payload());
    wait_idle(40);
    check("midrst_len", acc_bytes.size(), 17);
    if (acc_bytes.size() == 17) check("midrst_restart_sync", acc_bytes[0], 8'hA5);

    // back-to-back frames with ready held
    t0 = taken_cnt;
    ready   = 8'h3C;
    data_in = rand_payload();
    for (int i = 0; i < 60 && taken_cnt < t0 + 2; i++) step();
    ready = 8'h00;
    check("b2b_two_pulses", taken_cnt - t0, 2);
    check("b2b_period", last_taken - prev_taken, 18);
    wait_idle(40);

    // randomized traffic, backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      ready    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      data_in  = rand_payload();
      tx_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset    = 1'b0;
    ready    = 8'h00;
    tx_ready = 1'b1;
    step();
    wait_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ion_frame_serializer.md
ION_FRAME_SERIALIZER -- requirements
Module: ion_frame_serializer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-002 Parameter PAYLOAD_W, default 110, payload width in bits; the payload is zero-padded on the left to the next multiple of 8 (112 -> 14 bytes).
REQ-003 Port clock, input, 1, single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port ready, input, 8, per-sensor stream-ready mask from the ion stage; nonzero means a frame is offered.
REQ-006 Port data_in, input, PAYLOAD_W, sensor payload from the ion stage's data_out.
REQ-007 Port taken, output, 1, one-cycle pulse acknowledging capture of ready/data_in.
REQ-008 Port tx_data, output, 8, byte to the UART/Bluetooth transmitter.
REQ-009 Port tx_valid, output, 1, tx_data is valid.
REQ-010 Port tx_ready, input, 1, transmitter accepts the byte this cycle.
REQ-011 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 Frame order SHALL be: SYNC_BYTE, captured mask, 14 payload bytes MSB-first, checksum; 17 bytes total.
REQ-013 Checksum SHALL be the XOR of the mask byte and all 14 payload bytes; SYNC_BYTE is excluded.
REQ-014 The FSM SHALL have the states IDLE, SYNC, MASK, PAYLOAD and CHECK.
REQ-015 In IDLE with ready != 0, the block SHALL capture ready and data_in into internal registers, pulse taken for exactly one cycle, and enter SYNC on the next cycle.
REQ-016 In IDLE with ready == 0, the block SHALL hold; taken SHALL stay low.
REQ-017 In SYNC, MASK, PAYLOAD and CHECK, tx_valid SHALL be 1 and tx_data SHALL reflect the current byte.
REQ-018 The FSM SHALL advance only on a cycle where tx_valid && tx_ready.
REQ-019 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-020 Transitions SHALL be:
- SYNC -> MASK
- MASK -> PAYLOAD with byte index 0
- PAYLOAD increments the index each accepted byte; index 13 accepted -> CHECK
- CHECK accepted -> IDLE
REQ-021 The running checksum SHALL be accumulated on each accepted MASK/PAYLOAD byte; the accumulator SHALL clear on capture.
REQ-022 Changes on ready/data_in while busy SHALL be ignored; no taken pulse SHALL be issued while busy.
REQ-023 Back-to-back frames: a new capture MAY occur in the IDLE cycle immediately following CHECK acceptance; minimum frame period is 18 cycles with tx_ready held at 1.
REQ-024 Payload byte k (k=0..13) SHALL be bits [111-8k : 104-8k] of {2'b00, data_in}.
REQ-025 tx_valid SHALL be 0 in IDLE; tx_data SHALL be 8'h00 in IDLE.

Reset
REQ-026 On reset=1 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL reset to tx_valid=0, tx_data=0, taken=0, busy=0; the index, checksum and captured registers SHALL clear.
REQ-027 Reset mid-frame SHALL abort the frame with no further bytes emitted; the partial frame is not resumed.
REQ-028 Reset SHALL take priority over a simultaneous capture or tx handshake.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, SYNC_BYTE default, the frame length constant (17) and the payload byte count (14).
REQ-030 A single sub-module, frame_checksum (byte-wide XOR accumulator with clear/enable), SHALL be used; all other logic SHALL be flat.

Verification
REQ-031 Basic frame: ready=8'h01, data_in=110'h1 with tx_ready=1 -> bytes A5,01, then 00 x13, 01, then checksum 00; taken pulses once.
REQ-032 Checksum: ready=8'h80, data_in = all ones -> payload byte0=3F, bytes1..13=FF, checksum = 80^3F^FF = 40.
REQ-033 Backpressure: tx_ready toggles 0/1 every cycle -> same 17 bytes, each held stable while stalled, 34 cycles of tx_valid.
REQ-034 Busy ignore: change data_in and ready during the frame -> the emitted frame matches the captured values; no extra taken pulse.
REQ-035 Reset mid-frame: assert reset after byte 5 -> tx_valid=0 the next cycle, busy=0; a new frame starts cleanly with A5.
REQ-036 Back-to-back: ready held nonzero, tx_ready=1 -> second taken pulse exactly 18 cycles after the first.
